// File: rtl/bbus_pkg.sv
// Shared B-Bus definitions: initiator FSM states, latched request record and
// the VDP1 region base addresses used by responders and benches.
package bbus_pkg;
  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    TURN,
    DATA,
    DONE
  } bbus_state_e;

  typedef struct packed {
    logic        write;
    logic        long_acc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bbus_req_t;

  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [31:0] VDP1_VRAM_BASE = 32'h05C0_0000;
  localparam logic [31:0] VDP1_FB_BASE   = 32'h05C8_0000;
  localparam logic [31:0] VDP1_REG_BASE  = 32'h05D0_0000;
endpackage

// File: rtl/bbus_master.sv
// B-Bus initiator: turns one valid/ready request into the multiplexed
// address/data cycle sequence and returns one response per request.
module bbus_master
  import bbus_pkg::*;
#(
  parameter int ADDR_W   = 21,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT,
  parameter int TURN_CYC = 1
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_long,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              CS_N,
  output logic              AD_N,
  output logic              DTE_N,
  input  logic              READY_N,
  output logic [15:0]       VBUS_OUT,
  output logic              VBUS_OE,
  input  logic [15:0]       VBUS_IN
);
  localparam int CNT_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  bbus_state_e       state_q, state_d;
  bbus_req_t         req_q, req_d;
  logic              beat_q, beat_d;
  logic              gap_q, gap_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic [15:0]       hi_q, hi_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cs_n_q, cs_n_d;
  logic              ad_n_q, ad_n_d;
  logic              dte_n_q, dte_n_d;
  logic              oe_q, oe_d;
  logic [15:0]       vout_q, vout_d;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    beat_d      = beat_q;
    gap_d       = 1'b0;
    tmo_d       = tmo_q;
    turn_d      = turn_q;
    hi_d        = hi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // req_ready is registered high exactly while IDLE
        if (req_valid) begin
          req_d.write    = req_write;
          req_d.long_acc = req_long;
          req_d.addr     = 32'(req_addr) & ~32'd1;
          req_d.wdata    = req_wdata;
          beat_d         = 1'b0;
          state_d        = ADDR_HI;
        end
      end
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: begin
        tmo_d  = '0;
        turn_d = '0;
        if (req_q.write || TURN_CYC == 0) state_d = DATA;
        else                              state_d = TURN;
      end
      TURN: begin
        if (turn_q == TURN_W'(TURN_CYC - 1)) state_d = DATA;
        else                                 turn_d  = turn_q + 1'b1;
      end
      DATA: begin
        // The inter-beat gap cycle has DTE_N high, so READY_N is not a completion there
        if (!gap_q) begin
          if (!READY_N) begin
            tmo_d = '0;
            if (req_q.long_acc && !beat_q) begin
              beat_d = 1'b1;
              gap_d  = 1'b1;
              hi_d   = VBUS_IN;
            end else begin
              state_d     = DONE;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              if (req_q.write)         rsp_rdata_d = '0;
              else if (req_q.long_acc) rsp_rdata_d = {hi_q, VBUS_IN};
              else                     rsp_rdata_d = {16'h0000, VBUS_IN};
            end
          end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they are registered in step with it
  always_comb begin
    req_ready_d = (state_d == IDLE);
    cs_n_d      = 1'b1;
    ad_n_d      = 1'b1;
    dte_n_d     = 1'b1;
    oe_d        = 1'b0;
    vout_d      = '0;
    case (state_d)
      ADDR_HI: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_d   = 1'b1;
        vout_d = req_d.addr[31:16];
      end
      ADDR_LO: begin
        cs_n_d = 1'b0;
        ad_n_d = 1'b0;
        oe_d   = 1'b1;
        vout_d = req_d.addr[15:0];
      end
      TURN: cs_n_d = 1'b0;
      DATA: begin
        cs_n_d  = 1'b0;
        dte_n_d = gap_d;
        if (req_d.write) begin
          oe_d   = 1'b1;
          vout_d = (req_d.long_acc && !beat_d) ? req_d.wdata[31:16] : req_d.wdata[15:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      req_q       <= '0;
      beat_q      <= 1'b0;
      gap_q       <= 1'b0;
      tmo_q       <= '0;
      turn_q      <= '0;
      hi_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      ad_n_q      <= 1'b1;
      dte_n_q     <= 1'b1;
      oe_q        <= 1'b0;
      vout_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      turn_q      <= turn_d;
      hi_q        <= hi_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cs_n_q      <= cs_n_d;
      ad_n_q      <= ad_n_d;
      dte_n_q     <= dte_n_d;
      oe_q        <= oe_d;
      vout_q      <= vout_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign CS_N      = cs_n_q;
  assign AD_N      = ad_n_q;
  assign DTE_N     = dte_n_q;
  assign VBUS_OE   = oe_q;
  assign VBUS_OUT  = vout_q;
endmodule

// File: tb/tb_bbus_master.sv
// Bench for bbus_master: directed and random transactions against a
// transaction-level model, with a wait-state responder and a bus monitor.
module tb_bbus_master;
  localparam int ADDR_W   = 21;
  localparam int TIMEOUT  = 255;
  localparam int TURN_CYC = 1;

  logic              MCLK;
  logic              RESET_N;
  logic              req_valid, req_ready, req_write, req_long;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata, rsp_rdata;
  logic              rsp_valid, rsp_err;
  logic              CS_N, AD_N, DTE_N, READY_N, VBUS_OE;
  logic [15:0]       VBUS_OUT, VBUS_IN;

  int total = 0;
  int bad   = 0;

  bbus_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TURN_CYC(TURN_CYC)) dut (
    .MCLK(MCLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_long(req_long), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CS_N(CS_N), .AD_N(AD_N), .DTE_N(DTE_N), .READY_N(READY_N),
    .VBUS_OUT(VBUS_OUT), .VBUS_OE(VBUS_OE), .VBUS_IN(VBUS_IN)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  // Responder: per-beat wait states, one beat that never answers (stuck_beat)
  logic [15:0] rwords [2];
  int          waits  [2];
  int          stuck_beat;
  int          rbeat = 0;
  int          rcnt  = 0;

  always @(posedge MCLK) begin
    if (CS_N) begin
      rbeat <= 0;
      rcnt  <= 0;
    end else if (!DTE_N) begin
      if (!READY_N) begin
        rbeat <= rbeat + 1;
        rcnt  <= 0;
      end else begin
        rcnt <= rcnt + 1;
      end
    end
  end

  assign READY_N = !(!CS_N && !DTE_N && rbeat != stuck_beat && rcnt >= waits[rbeat[0]]);
  assign VBUS_IN = READY_N ? 16'hDEAD : rwords[rbeat[0]];

  // Bus monitor, sampled mid-cycle
  logic        cur_is_read;
  logic [15:0] addr_q[$];
  logic [15:0] wr_q[$];
  int          gap_cycles = 0;
  bit          after_beat = 0;
  int          rsp_seen   = 0;
  bit          prev_rsp   = 0;

  always @(negedge MCLK) begin
    if (!CS_N && AD_N && cur_is_read) check("oe_during_read", 32'(VBUS_OE), 0);
    if (!CS_N && !AD_N) begin
      addr_q.push_back(VBUS_OUT);
      check("oe_during_addr", 32'(VBUS_OE), 1);
    end
    if (!CS_N && AD_N && !DTE_N && !READY_N && !cur_is_read) wr_q.push_back(VBUS_OUT);
    if (CS_N) after_beat = 0;
    else if (!DTE_N && !READY_N) after_beat = 1;
    else if (!DTE_N) after_beat = 0;
    else if (after_beat && AD_N) gap_cycles++;
    if (rsp_valid) begin
      rsp_seen++;
      check("rsp_single_pulse", 32'(prev_rsp), 0);
    end
    prev_rsp = rsp_valid;
  end

  task automatic do_txn(input bit wr, input bit lg, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd, input int w0, input int w1,
                        input logic [15:0] r0, input logic [15:0] r1, input int stk);
    int          exp_lat, cyc, nbeats, exp_gap;
    logic [31:0] exp_rd;
    bit          exp_err;
    logic [15:0] exp_w[$];
    logic [15:0] exp_hi, exp_lo;

    nbeats  = lg ? 2 : 1;
    exp_err = (stk >= 0 && stk < nbeats);
    exp_lat = 2 + (wr ? 0 : TURN_CYC) + 1;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) exp_lat += 1;
      if (b == stk) begin
        exp_lat += TIMEOUT;
        break;
      end
      exp_lat += ((b == 0) ? w0 : w1) + 1;
      if (wr) exp_w.push_back((lg && b == 0) ? wd[31:16] : wd[15:0]);
    end
    if (exp_err || wr) exp_rd = 32'h0;
    else if (lg)       exp_rd = {r0, r1};
    else               exp_rd = {16'h0000, r0};
    exp_gap = (lg && stk != 0) ? 1 : 0;
    exp_hi  = 16'(addr >> 16);
    exp_lo  = {addr[15:1], 1'b0};

    waits[0] = w0; waits[1] = w1; rwords[0] = r0; rwords[1] = r1;
    stuck_beat = stk; cur_is_read = !wr;
    addr_q.delete(); wr_q.delete(); gap_cycles = 0;

    for (int i = 0; i < 10 && !req_ready; i++) step();
    check("ready_before_req", 32'(req_ready), 1);
    req_write = wr; req_long = lg; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 600) begin
      step();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    if (!wr) check("rsp_rdata", rsp_rdata, exp_rd);
    check("addr_words", 32'(addr_q.size()), 2);
    if (addr_q.size() >= 2) begin
      check("addr_hi", 32'(addr_q[0]), 32'(exp_hi));
      check("addr_lo", 32'(addr_q[1]), 32'(exp_lo));
    end
    check("wbeat_count", 32'(wr_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      if (i < wr_q.size()) check("wbeat_word", 32'(wr_q[i]), 32'(exp_w[i]));
    check("dte_gap", 32'(gap_cycles), 32'(exp_gap));
    step();
    check("rsp_one_cycle", 32'(rsp_valid), 0);
    check("cs_released", 32'(CS_N), 1);
    check("ready_after", 32'(req_ready), 1);
    if (!wr) check("rdata_hold", rsp_rdata, exp_rd);
  endtask

  int rc0, idx, run, min_gap;
  bit acc, seen_low;
  bit          r_wr, r_lg;
  int          r_w0, r_w1, r_stk;

  initial begin
    RESET_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_long = 1'b0;
    req_addr = '0; req_wdata = '0; stuck_beat = -1; cur_is_read = 1'b0;
    waits[0] = 0; waits[1] = 0; rwords[0] = '0; rwords[1] = '0;
    repeat (3) step();
    check("rst_cs_n", 32'(CS_N), 1);
    check("rst_ad_n", 32'(AD_N), 1);
    check("rst_dte_n", 32'(DTE_N), 1);
    check("rst_oe", 32'(VBUS_OE), 0);
    check("rst_vout", 32'(VBUS_OUT), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_ready", 32'(req_ready), 1);
    #2 RESET_N = 1'b1;
    step();

    do_txn(1'b1, 1'b0, 21'h100004, 32'h0000_1234, 0, 0, 16'h0, 16'h0, -1);
    do_txn(1'b0, 1'b1, 21'h080000, 32'h0, 2, 2, 16'hABCD, 16'h5678, -1);
    do_txn(1'b0, 1'b0, 21'h000100, 32'h0, 0, 0, 16'h1111, 16'h0, 0);
    do_txn(1'b1, 1'b1, 21'h1FFFFE, 32'h89AB_CDEF, 1, 0, 16'h0, 16'h0, -1);

    // Three queued writes with req_valid held high
    cur_is_read = 1'b0; stuck_beat = -1; waits[0] = 0; waits[1] = 0;
    wr_q.delete(); rc0 = rsp_seen; idx = 0; run = 0; seen_low = 0; min_gap = 1000;
    req_write = 1'b1; req_long = 1'b0; req_addr = 21'h000200; req_wdata = 32'h0000_A001;
    req_valid = 1'b1;
    for (int c = 0; c < 60 && (rsp_seen - rc0) < 3; c++) begin
      acc = req_ready && req_valid;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          req_addr  = 21'h000200 + 21'(idx * 2);
          req_wdata = 32'h0000_A001 + 32'(idx);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (CS_N) run++;
      else begin
        if (seen_low && run > 0 && run < min_gap) min_gap = run;
        run = 0;
        seen_low = 1;
        check("b2b_ready_low", 32'(req_ready), 0);
      end
    end
    check("b2b_rsp_count", 32'(rsp_seen - rc0), 3);
    check("b2b_cs_gap", 32'(min_gap >= 2 && min_gap < 1000), 1);
    check("b2b_words", 32'(wr_q.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < wr_q.size()) check("b2b_order", 32'(wr_q[i]), 32'hA001 + 32'(i));
    repeat (2) step();

    // Reset during the data beat of a long write
    cur_is_read = 1'b0; stuck_beat = 0;
    for (int i = 0; i < 10 && !req_ready; i++) step();
    req_write = 1'b1; req_long = 1'b1; req_addr = 21'h0C0010; req_wdata = 32'hCAFE_F00D;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && DTE_N; i++) step();
    check("rst_mid_in_data", 32'(DTE_N), 0);
    rc0 = rsp_seen;
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(CS_N), 1);
    check("rst_mid_dte_n", 32'(DTE_N), 1);
    check("rst_mid_ad_n", 32'(AD_N), 1);
    check("rst_mid_oe", 32'(VBUS_OE), 0);
    step(); step();
    #2 RESET_N = 1'b1;
    step();
    check("rst_mid_ready", 32'(req_ready), 1);
    check("rst_mid_cs_idle", 32'(CS_N), 1);
    repeat (6) step();
    check("rst_mid_no_rsp", 32'(rsp_seen - rc0), 0);
    stuck_beat = -1;

    for (int n = 0; n < 14; n++) begin
      r_wr  = 1'($urandom_range(0, 1));
      r_lg  = 1'($urandom_range(0, 1));
      r_w0  = $urandom_range(0, 3);
      r_w1  = $urandom_range(0, 3);
      r_stk = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 1) : -1;
      do_txn(r_wr, r_lg, 21'($urandom), $urandom, r_w0, r_w1,
             16'($urandom), 16'($urandom), r_stk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
